// File: rtl/dma_pkg.sv
// -----------------------------------------------------------------------------
// dma_pkg
// Shared DMA types: job descriptor, merged error record, error sources and
// the job-controller state encoding.
// -----------------------------------------------------------------------------
package dma_pkg;

    localparam int DMA_ADDR_W = 32;
    localparam int DMA_LEN_W  = 32;

    typedef enum logic [2:0] {
        DMA_NO_ERR        = 3'd0,
        DMA_SLVERR_ERR    = 3'd1,
        DMA_DECERR_ERR    = 3'd2,
        DMA_UNALIGNED_ERR = 3'd3,
        DMA_ABORT_ERR     = 3'd4,
        DMA_TIMEOUT_ERR   = 3'd5
    } dma_err_src_t;

    typedef struct packed {
        logic                  valid;
        dma_err_src_t          src;
        logic [DMA_ADDR_W-1:0] addr;
    } s_dma_error_t;

    typedef struct packed {
        logic [DMA_ADDR_W-1:0] src_addr;
        logic [DMA_ADDR_W-1:0] dst_addr;
        logic [DMA_LEN_W-1:0]  num_bytes;
    } s_dma_desc_t;

    typedef enum logic [2:0] {
        JOB_IDLE  = 3'd0,
        JOB_LOAD  = 3'd1,
        JOB_RUN   = 3'd2,
        JOB_DRAIN = 3'd3,
        JOB_FLUSH = 3'd4,
        JOB_DONE  = 3'd5
    } dma_job_st_t;

    // Builds a valid error record for errors raised by the job controller itself.
    function automatic s_dma_error_t dma_mk_err(dma_err_src_t src, logic [DMA_ADDR_W-1:0] addr);
        s_dma_error_t e;
        e.valid = 1'b1;
        e.src   = src;
        e.addr  = addr;
        return e;
    endfunction

endpackage

// File: rtl/dma_job_ctrl_if.sv
// -----------------------------------------------------------------------------
// dma_job_ctrl_if
// Streamer-side bundle of the DMA job controller: descriptor hand-off, the
// per-direction valid/done/error handshakes, write-response drain status and
// the flush strobe.
//   master : job controller side
//   slave  : read/write streamers and AXI write IF side
// -----------------------------------------------------------------------------
interface dma_job_ctrl_if;
    import dma_pkg::*;

    logic         dma_stream_go_o;
    s_dma_desc_t  dma_stream_desc_o;
    logic         dma_rd_stream_valid_o;
    logic         dma_wr_stream_valid_o;
    logic         dma_rd_stream_done_i;
    logic         dma_wr_stream_done_i;
    s_dma_error_t dma_rd_stream_err_i;
    s_dma_error_t dma_wr_stream_err_i;
    logic         dma_wr_bresp_pending_i;
    logic         dma_stream_flush_o;

    modport master (
        output dma_stream_go_o,
        output dma_stream_desc_o,
        output dma_rd_stream_valid_o,
        output dma_wr_stream_valid_o,
        input  dma_rd_stream_done_i,
        input  dma_wr_stream_done_i,
        input  dma_rd_stream_err_i,
        input  dma_wr_stream_err_i,
        input  dma_wr_bresp_pending_i,
        output dma_stream_flush_o
    );

    modport slave (
        input  dma_stream_go_o,
        input  dma_stream_desc_o,
        input  dma_rd_stream_valid_o,
        input  dma_wr_stream_valid_o,
        output dma_rd_stream_done_i,
        output dma_wr_stream_done_i,
        output dma_rd_stream_err_i,
        output dma_wr_stream_err_i,
        output dma_wr_bresp_pending_i,
        input  dma_stream_flush_o
    );

endinterface

// File: rtl/dma_job_ctrl.sv
// -----------------------------------------------------------------------------
// dma_job_ctrl
// Per-channel DMA job controller. Accepts one descriptor, launches the read
// and write streamers, waits for both done pulses and for write responses to
// drain, then emits one done pulse with a merged error record. Streamer
// errors, abort and a RUN/DRAIN watchdog divert the job through FLUSH.
//
// Ports:
//   clk, rstn        clock, asynchronous active-low reset
//   dma_go_i         job start pulse (IDLE only), samples dma_desc_i
//   dma_abort_i      abort request (LOAD/RUN/DRAIN only)
//   dma_desc_i       job descriptor
//   dma_busy_o       state != IDLE
//   dma_done_o       one-cycle completion pulse
//   dma_error_o      merged job error, held until the next accepted go
//   strm             streamer-side bundle (dma_job_ctrl_if.master)
//
// States:
//   JOB_IDLE  | waiting for go
//   JOB_LOAD  | one-cycle go pulse to both streamers
//   JOB_RUN   | streamers active until both done pulses seen
//   JOB_DRAIN | waiting for outstanding write responses
//   JOB_FLUSH | one-cycle clear of streamers after error/abort/timeout
//   JOB_DONE  | one-cycle completion pulse
// -----------------------------------------------------------------------------
module dma_job_ctrl
    import dma_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1048576
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         dma_go_i,
    input  logic         dma_abort_i,
    input  s_dma_desc_t  dma_desc_i,
    output logic         dma_busy_o,
    output logic         dma_done_o,
    output s_dma_error_t dma_error_o,
    dma_job_ctrl_if.master strm
);

    localparam int unsigned WDOG_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic WDOG_EN = (TIMEOUT_CYCLES != 0);
    // The watchdog fires on the cycle whose increment would reach the limit,
    // so FLUSH lands exactly TIMEOUT_CYCLES cycles after RUN entry.
    localparam logic [WDOG_W-1:0] WDOG_LAST =
        WDOG_W'((TIMEOUT_CYCLES > 0) ? (TIMEOUT_CYCLES - 1) : 0);

    dma_job_st_t       state_q, state_d;
    logic              rd_seen_q, rd_seen_d;
    logic              wr_seen_q, wr_seen_d;
    logic              rd_err_vld_q, wr_err_vld_q;
    logic [WDOG_W-1:0] wdog_q, wdog_d;
    s_dma_desc_t       desc_q, desc_d;
    s_dma_error_t      error_q, error_d;

    logic rd_err_rise;
    logic wr_err_rise;
    logic active;
    logic wdog_hit;

    always_comb begin
        state_d   = state_q;
        rd_seen_d = rd_seen_q;
        wr_seen_d = wr_seen_q;
        wdog_d    = wdog_q;
        desc_d    = desc_q;
        error_d   = error_q;

        rd_err_rise = strm.dma_rd_stream_err_i.valid & ~rd_err_vld_q;
        wr_err_rise = strm.dma_wr_stream_err_i.valid & ~wr_err_vld_q;
        active      = (state_q == JOB_RUN) || (state_q == JOB_DRAIN);
        wdog_hit    = WDOG_EN && active && (wdog_q == WDOG_LAST);

        if (active && (wdog_q != '1)) begin
            wdog_d = wdog_q + WDOG_W'(1);
        end

        case (state_q)
            JOB_IDLE: begin
                if (dma_go_i) begin
                    error_d   = '0;
                    rd_seen_d = 1'b0;
                    wr_seen_d = 1'b0;
                    wdog_d    = '0;
                    if (dma_desc_i.num_bytes != '0) begin
                        desc_d  = dma_desc_i;
                        state_d = JOB_LOAD;
                    end else begin
                        state_d = JOB_DONE;
                    end
                end
            end
            JOB_LOAD: begin
                if (dma_abort_i) begin
                    error_d = dma_mk_err(DMA_ABORT_ERR, desc_q.src_addr);
                    state_d = JOB_FLUSH;
                end else begin
                    state_d = JOB_RUN;
                end
            end
            JOB_RUN, JOB_DRAIN: begin
                if (rd_err_rise) begin
                    error_d = strm.dma_rd_stream_err_i;
                    state_d = JOB_FLUSH;
                end else if (wr_err_rise) begin
                    error_d = strm.dma_wr_stream_err_i;
                    state_d = JOB_FLUSH;
                end else if (dma_abort_i) begin
                    error_d = dma_mk_err(DMA_ABORT_ERR, desc_q.src_addr);
                    state_d = JOB_FLUSH;
                end else if (wdog_hit) begin
                    // Timeout reports the job's source address for traceability.
                    error_d = dma_mk_err(DMA_TIMEOUT_ERR, desc_q.src_addr);
                    state_d = JOB_FLUSH;
                end else if (state_q == JOB_RUN) begin
                    rd_seen_d = rd_seen_q | strm.dma_rd_stream_done_i;
                    wr_seen_d = wr_seen_q | strm.dma_wr_stream_done_i;
                    if (rd_seen_d && wr_seen_d) begin
                        state_d = JOB_DRAIN;
                    end
                end else if (!strm.dma_wr_bresp_pending_i) begin
                    state_d = JOB_DONE;
                end
            end
            JOB_FLUSH: state_d = JOB_DONE;
            JOB_DONE:  state_d = JOB_IDLE;
            default:   state_d = JOB_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= JOB_IDLE;
            rd_seen_q    <= 1'b0;
            wr_seen_q    <= 1'b0;
            rd_err_vld_q <= 1'b0;
            wr_err_vld_q <= 1'b0;
            wdog_q       <= '0;
            desc_q       <= '0;
            error_q      <= '0;
        end else begin
            state_q      <= state_d;
            rd_seen_q    <= rd_seen_d;
            wr_seen_q    <= wr_seen_d;
            // Error valids are tracked every cycle so only a fresh rise counts.
            rd_err_vld_q <= strm.dma_rd_stream_err_i.valid;
            wr_err_vld_q <= strm.dma_wr_stream_err_i.valid;
            wdog_q       <= wdog_d;
            desc_q       <= desc_d;
            error_q      <= error_d;
        end
    end

    assign dma_busy_o  = (state_q != JOB_IDLE);
    assign dma_done_o  = (state_q == JOB_DONE);
    assign dma_error_o = error_q;

    assign strm.dma_stream_go_o       = (state_q == JOB_LOAD);
    assign strm.dma_stream_desc_o     = desc_q;
    assign strm.dma_rd_stream_valid_o = (state_q == JOB_RUN) & ~rd_seen_q;
    assign strm.dma_wr_stream_valid_o = (state_q == JOB_RUN) & ~wr_seen_q;
    assign strm.dma_stream_flush_o    = (state_q == JOB_FLUSH);

endmodule

// File: tb/tb_dma_job_ctrl.sv
// -----------------------------------------------------------------------------
// tb_dma_job_ctrl
// Directed bench for dma_job_ctrl with TIMEOUT_CYCLES = 16. Stimulus pushes
// expected go/flush/done events into queues; monitors pop them when the DUT
// presents the matching strobe. Inputs and outputs are handled on the falling
// edge; "cycle c" is the negedge at which cyc == c.
// -----------------------------------------------------------------------------
module tb_dma_job_ctrl;
    import dma_pkg::*;

    logic         clk = 1'b0;
    logic         rstn = 1'b1;
    logic         go;
    logic         abort;
    s_dma_desc_t  desc_in;
    logic         busy;
    logic         done;
    s_dma_error_t err_out;

    dma_job_ctrl_if strm();

    dma_job_ctrl #(.TIMEOUT_CYCLES(16)) dut (
        .clk         (clk),
        .rstn        (rstn),
        .dma_go_i    (go),
        .dma_abort_i (abort),
        .dma_desc_i  (desc_in),
        .dma_busy_o  (busy),
        .dma_done_o  (done),
        .dma_error_o (err_out),
        .strm        (strm)
    );

    always #5 clk = ~clk;

    int cyc;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks;
    int n_errors;

    typedef struct {
        int           cyc;
        s_dma_error_t err;
    } exp_done_t;

    exp_done_t done_q[$];
    int        go_q[$];
    int        flush_q[$];

    function automatic void chk(string name, logic [127:0] act, logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    function automatic void unexpected(string name);
        n_checks++;
        n_errors++;
        $display("FAIL %s: strobe seen at cycle %0d, none required", name, cyc);
    endfunction

    function automatic s_dma_error_t mk_err(dma_err_src_t src, logic [31:0] addr);
        s_dma_error_t e;
        e.valid = 1'b1;
        e.src   = src;
        e.addr  = addr;
        return e;
    endfunction

    function automatic s_dma_desc_t mk_desc(logic [31:0] s, logic [31:0] d, logic [31:0] n);
        s_dma_desc_t r;
        r.src_addr  = s;
        r.dst_addr  = d;
        r.num_bytes = n;
        return r;
    endfunction

    function automatic void push_done(int c, s_dma_error_t e);
        exp_done_t x;
        x.cyc = c;
        x.err = e;
        done_q.push_back(x);
    endfunction

    task automatic at(int c);
        while (cyc < c) @(negedge clk);
    endtask

    // Monitors
    always @(negedge clk) begin : mon_done
        exp_done_t e;
        if (rstn && done) begin
            if (done_q.size() == 0) unexpected("done_unexpected");
            else begin
                e = done_q.pop_front();
                chk("done_cycle", cyc, e.cyc);
                chk("done_error", err_out, e.err);
            end
        end
    end

    always @(negedge clk) begin : mon_go
        int c;
        if (rstn && strm.dma_stream_go_o) begin
            if (go_q.size() == 0) unexpected("stream_go_unexpected");
            else begin
                c = go_q.pop_front();
                chk("stream_go_cycle", cyc, c);
            end
        end
    end

    always @(negedge clk) begin : mon_flush
        int c;
        if (rstn && strm.dma_stream_flush_o) begin
            if (flush_q.size() == 0) unexpected("flush_unexpected");
            else begin
                c = flush_q.pop_front();
                chk("flush_cycle", cyc, c);
            end
        end
    end

    initial begin : stim
        int n;
        int e;
        int g;
        go      = 1'b0;
        abort   = 1'b0;
        desc_in = '0;
        strm.dma_rd_stream_done_i   = 1'b0;
        strm.dma_wr_stream_done_i   = 1'b0;
        strm.dma_rd_stream_err_i    = '0;
        strm.dma_wr_stream_err_i    = '0;
        strm.dma_wr_bresp_pending_i = 1'b0;

        #1 rstn = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_error", err_out, 0);
        chk("rst_stream_desc", strm.dma_stream_desc_o, 0);
        chk("rst_stream_go", strm.dma_stream_go_o, 0);
        chk("rst_rd_valid", strm.dma_rd_stream_valid_o, 0);
        chk("rst_wr_valid", strm.dma_wr_stream_valid_o, 0);
        chk("rst_flush", strm.dma_stream_flush_o, 0);
        rstn = 1'b1;

        // Normal 256-byte job with B drain; go during busy ignored
        n = cyc + 2;
        at(n);
        go = 1'b1;
        desc_in = mk_desc(32'h1000, 32'h2000, 32'd256);
        go_q.push_back(n + 1);
        push_done(n + 13, '0);
        at(n + 1);
        go = 1'b0;
        chk("t1_stream_desc", strm.dma_stream_desc_o, mk_desc(32'h1000, 32'h2000, 32'd256));
        at(n + 2);
        chk("t1_rd_valid_run", strm.dma_rd_stream_valid_o, 1);
        chk("t1_wr_valid_run", strm.dma_wr_stream_valid_o, 1);
        at(n + 3);
        strm.dma_wr_bresp_pending_i = 1'b1;
        at(n + 4);
        go = 1'b1;
        desc_in = mk_desc(32'hDEAD0000, 32'h0, 32'd0);
        at(n + 5);
        go = 1'b0;
        chk("t1_desc_kept", strm.dma_stream_desc_o, mk_desc(32'h1000, 32'h2000, 32'd256));
        chk("t1_busy", busy, 1);
        at(n + 6);
        strm.dma_rd_stream_done_i = 1'b1;
        at(n + 7);
        strm.dma_rd_stream_done_i = 1'b0;
        chk("t1_rd_valid_low", strm.dma_rd_stream_valid_o, 0);
        chk("t1_wr_valid_still", strm.dma_wr_stream_valid_o, 1);
        at(n + 9);
        strm.dma_wr_stream_done_i = 1'b1;
        at(n + 10);
        strm.dma_wr_stream_done_i = 1'b0;
        chk("t1_wr_valid_low", strm.dma_wr_stream_valid_o, 0);
        at(n + 12);
        strm.dma_wr_bresp_pending_i = 1'b0;
        at(n + 15);

        // Zero-byte job
        n = cyc + 1;
        at(n);
        go = 1'b1;
        desc_in = mk_desc(32'h10, 32'h20, 32'd0);
        push_done(n + 1, '0);
        at(n + 1);
        go = 1'b0;
        chk("t2_busy_n1", busy, 1);
        at(n + 2);
        chk("t2_busy_n2", busy, 0);

        // Write-streamer unaligned error in RUN
        n = cyc + 2;
        e = n + 4;
        at(n);
        go = 1'b1;
        desc_in = mk_desc(32'h1000, 32'h1004, 32'd64);
        go_q.push_back(n + 1);
        flush_q.push_back(e + 1);
        push_done(e + 2, mk_err(DMA_UNALIGNED_ERR, 32'h1004));
        at(n + 1);
        go = 1'b0;
        at(e);
        strm.dma_wr_stream_err_i = mk_err(DMA_UNALIGNED_ERR, 32'h1004);
        at(e + 1);
        chk("t3_error_at_flush", err_out, mk_err(DMA_UNALIGNED_ERR, 32'h1004));
        strm.dma_wr_stream_err_i = '0;
        at(e + 4);

        // Read error and abort in the same cycle: read error wins
        n = cyc + 2;
        e = n + 3;
        at(n);
        go = 1'b1;
        desc_in = mk_desc(32'h2000, 32'h2400, 32'd128);
        go_q.push_back(n + 1);
        flush_q.push_back(e + 1);
        push_done(e + 2, mk_err(DMA_SLVERR_ERR, 32'h2040));
        at(n + 1);
        go = 1'b0;
        at(e);
        strm.dma_rd_stream_err_i = mk_err(DMA_SLVERR_ERR, 32'h2040);
        abort = 1'b1;
        at(e + 1);
        abort = 1'b0;
        strm.dma_rd_stream_err_i = '0;
        at(e + 4);
        chk("t4_error_held", err_out, mk_err(DMA_SLVERR_ERR, 32'h2040));

        // Second go clears the error; abort in RUN
        g = cyc + 1;
        at(g);
        go = 1'b1;
        desc_in = mk_desc(32'h3000, 32'h3800, 32'd128);
        go_q.push_back(g + 1);
        flush_q.push_back(g + 3);
        push_done(g + 4, mk_err(DMA_ABORT_ERR, 32'h3000));
        at(g + 1);
        go = 1'b0;
        chk("t5_error_cleared", err_out, 0);
        at(g + 2);
        abort = 1'b1;
        at(g + 3);
        abort = 1'b0;
        at(g + 6);

        // Watchdog: streamers never finish
        n = cyc + 1;
        at(n);
        go = 1'b1;
        desc_in = mk_desc(32'h5000, 32'h6000, 32'd512);
        go_q.push_back(n + 1);
        flush_q.push_back(n + 18);
        push_done(n + 19, mk_err(DMA_TIMEOUT_ERR, 32'h5000));
        at(n + 1);
        go = 1'b0;
        at(n + 17);
        chk("t6_rd_valid_before_to", strm.dma_rd_stream_valid_o, 1);
        chk("t6_wr_valid_before_to", strm.dma_wr_stream_valid_o, 1);
        at(n + 23);
        chk("t6_idle_after", busy, 0);

        chk("done_queue_drained", done_q.size(), 0);
        chk("go_queue_drained", go_q.size(), 0);
        chk("flush_queue_drained", flush_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/dma_job_ctrl.md
# dma_job_ctrl

Per-channel DMA job controller sitting directly upstream of the read and write `dma_streamer` instances. It accepts one descriptor from the CSR/scheduler side and hands it to both streamers. It sequences their `valid`/`done` handshakes and waits for outstanding write responses to drain. It then reports a single completion pulse with a merged error record, and provides abort and watchdog-timeout recovery.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 1048576: watchdog limit on cycles spent in RUN plus DRAIN; 0 disables the watchdog.

Ports:
- `clk` in 1: single clock.
- `rstn` in 1: asynchronous active-low reset.
- `dma_go_i` in 1: job start pulse; honoured only in IDLE.
- `dma_abort_i` in 1: abort request; honoured in LOAD, RUN and DRAIN.
- `dma_desc_i` in `s_dma_desc_t`: job descriptor, sampled with `dma_go_i`.
- `dma_busy_o` out 1: high whenever state ≠ IDLE.
- `dma_done_o` out 1: one-cycle completion pulse (success or error).
- `dma_error_o` out `s_dma_error_t`: merged job error; held until the next accepted go.
- `dma_stream_go_o` out 1: one-cycle pulse to both streamers' `dma_go_i`.
- `dma_stream_desc_o` out `s_dma_desc_t`: registered descriptor to both streamers.
- `dma_rd_stream_valid_o` out 1: read streamer `dma_stream_valid_i`.
- `dma_wr_stream_valid_o` out 1: write streamer `dma_stream_valid_i`.
- `dma_rd_stream_done_i` in 1: read streamer done pulse.
- `dma_wr_stream_done_i` in 1: write streamer done pulse.
- `dma_rd_stream_err_i` in `s_dma_error_t`: read streamer error.
- `dma_wr_stream_err_i` in `s_dma_error_t`: write streamer error.
- `dma_wr_bresp_pending_i` in 1: write AXI IF has outstanding B responses.
- `dma_stream_flush_o` out 1: one-cycle synchronous clear to the streamers and AXI IFs.

## Operation
- States: IDLE, LOAD, RUN, DRAIN, FLUSH, DONE.
- IDLE → LOAD on `dma_go_i` with `num_bytes` ≠ 0. This captures the descriptor, clears `dma_error_o`, clears the `rd_seen`/`wr_seen` flags and clears the watchdog.
- IDLE → DONE on `dma_go_i` with `num_bytes` == 0: error cleared, no streamer activity.
- LOAD: `dma_stream_go_o` = 1 for exactly this one cycle. Then → RUN.
- RUN: `dma_rd_stream_valid_o` = ~`rd_seen`; `dma_wr_stream_valid_o` = ~`wr_seen`.
  - A done pulse sets the matching seen flag. Valid therefore falls the cycle after the done pulse, which prevents streamer restart.
  - When both flags are set, or both done pulses arrive in the same cycle → DRAIN.
- DRAIN: both valids low; → DONE when `dma_wr_bresp_pending_i` == 0.
- Error detection in RUN/DRAIN: a rising edge of `err_i.valid` on either streamer records the error into `dma_error_o`. If both rise in the same cycle, the read error wins. The job then → FLUSH.
- `dma_abort_i` in LOAD/RUN/DRAIN: record `src` = `DMA_ABORT_ERR`, `addr` = descriptor `src_addr`, then → FLUSH.
- Watchdog: a counter increments each cycle in RUN/DRAIN. When it reaches `TIMEOUT_CYCLES`, record `DMA_TIMEOUT_ERR` and → FLUSH.
- Priority within one cycle: streamer error > abort > timeout > normal transition.
- FLUSH: `dma_stream_flush_o` = 1 for one cycle, both valids low, then → DONE.
- DONE: `dma_done_o` = 1 for one cycle, then → IDLE.
- `dma_go_i` outside IDLE is ignored with no side effect; `dma_abort_i` in IDLE, FLUSH or DONE is ignored.
- Counter width: `$clog2(TIMEOUT_CYCLES+1)`, saturating; it never wraps.

## Timing
- Reset: state IDLE; all outputs 0 (`dma_error_o` = `'0`, `dma_stream_desc_o` = `'0`); flags and counter cleared. Reset mid-job abandons the job immediately with no done pulse.
- Go at cycle N:
  - LOAD at N+1 (`dma_stream_go_o`, `dma_stream_desc_o` valid).
  - RUN at N+2, with both valids high from N+2.
- Zero-byte job: `dma_done_o` at N+1.
- Streamer done at cycle M: that valid is low from M+1.
- Last done at M with no pending B: DRAIN at M+1, DONE at M+2.
- Error or abort sampled at cycle E: FLUSH at E+1, DONE at E+2, `dma_error_o` valid from E+1.
- All outputs are registered or decoded directly from state/flag registers; there are no combinational input→output paths.

## Structure
- Add to `dma_pkg`:
  - `dma_job_st_t` enum.
  - `DMA_ABORT_ERR` and `DMA_TIMEOUT_ERR` members of the existing error-source enum.
- `s_dma_desc_t` and `s_dma_error_t` are reused unchanged.
- No sub-module; single FSM with a flag and counter datapath.

## Test plan
- Go, `num_bytes` = 256, aligned addresses; rd done at N+6, wr done at N+9, B pending until N+12 → `dma_done_o` at N+13, `dma_error_o.valid` = 0, each valid low the cycle after its done.
- Go, `num_bytes` = 0 → `dma_done_o` at N+1, `dma_stream_go_o` never asserts, busy high only in cycle N+1.
- Write-streamer error rises at E in RUN (`DMA_UNALIGNED_ERR`, addr 0x1004) → flush at E+1, done at E+2, `dma_error_o` = {1, `DMA_UNALIGNED_ERR`, 0x1004}.
- `TIMEOUT_CYCLES` = 16, streamers never done → FLUSH exactly 16 cycles after RUN entry, error src `DMA_TIMEOUT_ERR`, done one cycle later.
- Abort in the same cycle as the rd error rise → rd error recorded, not abort. Go pulses during busy are ignored. A second go after done clears `dma_error_o`.
